// File: rtl/div_pkg.sv
// Shared types and sizing for the sequential signed divider.
package div_pkg;

  // Controller states of the divider.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } div_state_e;

  // Default operand width and the matching iteration-counter width.
  localparam int DIV_N = 16;
  localparam int CNT_W = $clog2(DIV_N) + 1;

  // Counter width for an arbitrary operand width.
  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/seq_signed_divider_twos_abs.sv
// Two's-complement magnitude and sign extraction. The most negative value
// maps to 2^(N-1), which is still representable as an N-bit unsigned number.
module twos_abs #(
  parameter int N = 16
) (
  input  logic [N-1:0] val_i,
  output logic [N-1:0] mag_o,
  output logic         neg_o
);

  assign neg_o = val_i[N-1];
  assign mag_o = neg_o ? (~val_i + 1'b1) : val_i;

endmodule

// File: rtl/seq_signed_divider.sv
// Iterative signed divider: restoring division on magnitudes, one quotient
// bit per clock, followed by a sign-correction cycle.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; special cases resolved on the accept edge
// CALC    | N restoring iterations, MSB first
// FIX     | apply quotient / remainder signs
// DONE    | one-cycle done pulse, results valid
module seq_signed_divider
  import div_pkg::*;
#(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero,
  output logic         overflow
);

  localparam int CW = cnt_width(N);
  localparam logic [N-1:0] MIN_VAL = {1'b1, {(N-1){1'b0}}};

  div_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  // Kept remainder is always below |divisor| <= 2^(N-1), so N bits hold it;
  // the shifted working value below carries the extra (N+1)th bit.
  logic [N-1:0]  prem_q, prem_d;
  // Dividend magnitude shifts out at the top while quotient bits enter below.
  logic [N-1:0]  acc_q, acc_d;
  logic [N-1:0]  dvsr_q, dvsr_d;
  logic          negq_q, negq_d;
  logic          negr_q, negr_d;
  logic [N-1:0]  quo_q, quo_d;
  logic [N-1:0]  rout_q, rout_d;
  logic          dbz_q, dbz_d;
  logic          ovf_q, ovf_d;

  logic [N-1:0]  dvd_mag, dvs_mag;
  logic          dvd_neg, dvs_neg;
  logic [N:0]    prem_shift;
  logic [N:0]    trial;
  logic          is_div0;
  logic          is_ovf;

  twos_abs #(.N(N)) u_abs_dvd (
    .val_i (dividend),
    .mag_o (dvd_mag),
    .neg_o (dvd_neg)
  );

  twos_abs #(.N(N)) u_abs_dvs (
    .val_i (divisor),
    .mag_o (dvs_mag),
    .neg_o (dvs_neg)
  );

  assign prem_shift = {prem_q, acc_q[N-1]};
  assign trial      = prem_shift - {1'b0, dvsr_q};
  assign is_div0    = (divisor == '0);
  assign is_ovf     = (dividend == MIN_VAL) && (divisor == '1);

  // Next-state and datapath updates; every register holds by default.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prem_d  = prem_q;
    acc_d   = acc_q;
    dvsr_d  = dvsr_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    quo_d   = quo_q;
    rout_d  = rout_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          dbz_d = 1'b0;
          ovf_d = 1'b0;
          if (is_div0) begin
            quo_d   = '1;
            rout_d  = dividend;
            dbz_d   = 1'b1;
            state_d = ST_DONE;
          end else if (is_ovf) begin
            quo_d   = MIN_VAL;
            rout_d  = '0;
            ovf_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            acc_d   = dvd_mag;
            dvsr_d  = dvs_mag;
            negq_d  = dvd_neg ^ dvs_neg;
            negr_d  = dvd_neg;
            prem_d  = '0;
            cnt_d   = '0;
            state_d = ST_CALC;
          end
        end
      end

      ST_CALC: begin
        if (!trial[N]) begin
          prem_d = trial[N-1:0];
          acc_d  = {acc_q[N-2:0], 1'b1};
        end else begin
          prem_d = prem_shift[N-1:0];
          acc_d  = {acc_q[N-2:0], 1'b0};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          state_d = ST_FIX;
        end
      end

      ST_FIX: begin
        quo_d   = negq_q ? (~acc_q + 1'b1) : acc_q;
        rout_d  = negr_q ? (~prem_q + 1'b1) : prem_q;
        state_d = ST_DONE;
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      prem_q  <= '0;
      acc_q   <= '0;
      dvsr_q  <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      quo_q   <= '0;
      rout_q  <= '0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prem_q  <= prem_d;
      acc_q   <= acc_d;
      dvsr_q  <= dvsr_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      quo_q   <= quo_d;
      rout_q  <= rout_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);
  assign quotient    = quo_q;
  assign remainder   = rout_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_seq_signed_divider.sv
// Self-checking bench for seq_signed_divider: directed corner cases plus
// random operands against an arithmetic reference model.
module tb_seq_signed_divider;

  localparam int N = 16;
  localparam int LAT_NORMAL = N + 1;

  logic          clk;
  logic          rst;
  logic          start;
  logic [N-1:0]  dividend;
  logic [N-1:0]  divisor;
  logic          busy;
  logic          done;
  logic [N-1:0]  quotient;
  logic [N-1:0]  remainder;
  logic          div_by_zero;
  logic          overflow;

  int errors = 0;
  int checks = 0;

  seq_signed_divider #(.N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain signed arithmetic plus the two special cases.
  task automatic model(input logic [15:0] a, input logic [15:0] b,
                       output logic [15:0] q, output logic [15:0] r,
                       output logic dz, output logic ov, output int lat);
    int ai;
    int bi;
    ai = int'($signed(a));
    bi = int'($signed(b));
    dz = 1'b0;
    ov = 1'b0;
    if (bi == 0) begin
      q = 16'hFFFF; r = a; dz = 1'b1; lat = 0;
    end else if (ai == -32768 && bi == -1) begin
      q = 16'h8000; r = 16'h0000; ov = 1'b1; lat = 0;
    end else begin
      q = 16'(ai / bi); r = 16'(ai % bi); lat = LAT_NORMAL;
    end
  endtask

  // Called 1ns after an edge with the DUT idle; returns 1ns after the accept edge.
  task automatic start_op(input logic [15:0] a, input logic [15:0] b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
  endtask

  // Counts edges after the accept edge until done; busy must stay high meanwhile.
  task automatic wait_done(output int lat, output bit busy_ok);
    lat = 0;
    busy_ok = 1'b1;
    while (!done && lat < 40) begin
      if (!busy) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    if (!busy) busy_ok = 1'b0;
  endtask

  task automatic check_res(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input int lat, input bit busy_ok);
    logic [15:0] eq, er;
    logic edz, eov;
    int elat;
    model(a, b, eq, er, edz, eov, elat);
    chk({tag, "_latency"}, 32'(lat), 32'(elat));
    chk({tag, "_busy"}, 32'(busy_ok), 32'(1));
    chk({tag, "_quotient"}, 32'(quotient), 32'(eq));
    chk({tag, "_remainder"}, 32'(remainder), 32'(er));
    chk({tag, "_div_by_zero"}, 32'(div_by_zero), 32'(edz));
    chk({tag, "_overflow"}, 32'(overflow), 32'(eov));
  endtask

  // One edge after done: pulse over, idle, results held.
  task automatic post_done(input string tag);
    logic [15:0] q_before;
    q_before = quotient;
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, 32'(done), 32'(0));
    chk({tag, "_busy_clear"}, 32'(busy), 32'(0));
    chk({tag, "_hold"}, 32'(quotient), 32'(q_before));
  endtask

  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b);
    int lat;
    bit bok;
    start_op(a, b);
    wait_done(lat, bok);
    check_res(tag, a, b, lat, bok);
    post_done(tag);
  endtask

  initial begin
    int lat;
    bit bok;
    bit seen;
    logic [15:0] ra, rb;

    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_quotient", 32'(quotient), 32'(0));
    chk("rst_remainder", 32'(remainder), 32'(0));
    chk("rst_dbz", 32'(div_by_zero), 32'(0));
    chk("rst_ovf", 32'(overflow), 32'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    run_op("100_7",   16'd100,   16'd7);
    run_op("m7_2",    16'hFFF9,  16'd2);
    run_op("7_m2",    16'd7,     16'hFFFE);
    run_op("m7_m2",   16'hFFF9,  16'hFFFE);
    run_op("5_0",     16'd5,     16'd0);
    run_op("min_m1",  16'h8000,  16'hFFFF);
    run_op("min_1",   16'h8000,  16'd1);
    run_op("3_5",     16'd3,     16'd5);
    run_op("min_min", 16'h8000,  16'h8000);
    run_op("0_m3",    16'd0,     16'hFFFD);

    // A start pulse mid-operation with different operands must be ignored.
    start_op(16'd1000, 16'd3);
    repeat (4) begin @(posedge clk); #1; end
    dividend = 16'd9; divisor = 16'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat, bok);
    check_res("ignored_start", 16'd1000, 16'd3, lat + 5, bok);
    post_done("ignored_start");

    // Start held high: the second request is taken on the first idle edge.
    dividend = 16'hFB2E; divisor = 16'd17; start = 1'b1;
    @(posedge clk); #1;
    dividend = 16'd30000; divisor = 16'hFFF9;
    wait_done(lat, bok);
    check_res("held_first", 16'hFB2E, 16'd17, lat, bok);
    @(posedge clk); #1;
    chk("held_gap_busy", 32'(busy), 32'(0));
    chk("held_gap_done", 32'(done), 32'(0));
    @(posedge clk); #1;
    chk("held_accept", 32'(busy), 32'(1));
    start = 1'b0;
    wait_done(lat, bok);
    check_res("held_second", 16'd30000, 16'hFFF9, lat, bok);
    post_done("held_second");

    // Reset in the middle of an operation.
    start_op(16'd100, 16'd7);
    repeat (7) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_busy", 32'(busy), 32'(0));
    chk("midrst_done", 32'(done), 32'(0));
    chk("midrst_quotient", 32'(quotient), 32'(0));
    chk("midrst_remainder", 32'(remainder), 32'(0));
    chk("midrst_dbz", 32'(div_by_zero), 32'(0));
    chk("midrst_ovf", 32'(overflow), 32'(0));
    rst = 1'b0;
    seen = 1'b0;
    repeat (25) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    chk("midrst_no_done", 32'(seen), 32'(0));
    run_op("after_rst", 16'd100, 16'd7);

    // Random operands, with the special cases mixed in.
    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom);
      case ($urandom_range(0, 9))
        0: rb = 16'd0;
        1: begin ra = 16'h8000; rb = 16'hFFFF; end
        2: rb = 16'($urandom_range(1, 20));
        3: rb = 16'(-$urandom_range(1, 20));
        default: rb = 16'($urandom);
      endcase
      run_op("random", ra, rb);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_signed_divider.md
Name: seq_signed_divider

Overview:
- Iterative signed integer divider. It is the inverse datapath of the team's combinational Booth multiplier (product = A*B; this block recovers A = P/B).
- Restoring algorithm on magnitudes, one quotient bit per clock, then sign correction.
- Sits beside the multiplier in the ALU/execute stage. The CPU control drives it with a start/done handshake.

Parameters:
- N, 16, operand width in bits. Dividend, divisor, quotient and remainder are all N bits, two's complement.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; accepted only when busy=0
- dividend  input  N  signed dividend, sampled on the accepting edge
- divisor  input  N  signed divisor, sampled on the accepting edge
- busy  output  1  high from the accepting edge until done is asserted
- done  output  1  one-cycle pulse; results valid in that cycle
- quotient  output  N  signed quotient, truncated toward zero
- remainder  output  N  signed remainder; sign follows the dividend; |remainder| < |divisor|
- div_by_zero  output  1  flag, valid with done
- overflow  output  1  flag, valid with done

Behaviour:
- Reset (rst=1 at a rising edge):
  - state goes to IDLE
  - busy, done, quotient, remainder, div_by_zero and overflow all go to 0
  - reset overrides any operation in progress, and no done is produced for it
- States are IDLE, CALC, FIX, DONE.
- IDLE:
  - start=1 latches the operands, sets busy=1 and clears both flags.
  - Divisor==0: go to DONE. Result is quotient={N{1'b1}}, remainder=dividend, div_by_zero=1.
  - Dividend==-2^(N-1) and divisor==-1: go to DONE. Result is quotient=-2^(N-1) (0x8000 for N=16), remainder=0, overflow=1.
  - Otherwise:
    - store |dividend| and |divisor| as N-bit unsigned; 2^(N-1) is representable
    - store the operand signs
    - clear the (N+1)-bit partial remainder
    - clear the iteration counter
    - go to CALC
- CALC runs exactly N cycles, MSB first:
  - shift the partial remainder left and bring in the next dividend-magnitude bit
  - trial-subtract |divisor|
  - if the result is non-negative, keep it and set the quotient bit to 1; otherwise restore and set the bit to 0
  - after the Nth iteration, go to FIX
- FIX:
  - negate the quotient if the operand signs differ
  - negate the remainder if the dividend is negative
  - go to DONE
- DONE:
  - done=1 for exactly one cycle, and results/flags are stable
  - next state IDLE; busy=0 from the following edge
- Latency, counting the accepting edge as edge 0:
  - normal path: done is high in the cycle after edge N+1, i.e. N+2 cycles (18 for N=16)
  - special-case paths: done is high in the cycle after edge 0 (1 cycle)
- Outputs hold their last values after done until the next accepted start. Only the flags are cleared, on the accepting edge.
- start while busy=1 is ignored, and operand changes while busy have no effect.
- start held high continuously: a new operation is accepted on the first edge with busy=0, i.e. the edge after the done cycle. Back-to-back throughput is one operation per N+3 cycles.
- The datapath is fully registered. There is no combinational path from any input to any output.

Decomposition:
- Shared package (div_pkg):
  - state encoding typedef (IDLE/CALC/FIX/DONE)
  - localparam for the counter width, $clog2(N)+1
- No sub-module required. Optionally, split the magnitude/negate helper into the combinational sub-module twos_abs (N-bit abs value plus sign out), which is reusable by the multiplier path.

Test Plan:
- dividend=100, divisor=7 -> quotient=14, remainder=2, no flags; done exactly 18 cycles after the start edge, busy high throughout.
- -7/2 -> quotient=-3 (0xFFFD), remainder=-1 (0xFFFF); and 7/-2 -> quotient=-3, remainder=1; and -7/-2 -> quotient=3, remainder=-1.
- 5/0 -> quotient=0xFFFF, remainder=5, div_by_zero=1, done 1 cycle after start; then -32768/-1 -> quotient=0x8000, remainder=0, overflow=1.
- -32768/1 -> quotient=0x8000, remainder=0, overflow=0 (normal path, 18 cycles); and 3/5 -> quotient=0, remainder=3.
- Start 1000/3, pulse start with 9/9 at cycle 5 -> second request ignored, result 333 r 1; with start held high, the next operation begins on the edge after done.
- Assert rst at cycle 8 of 100/7 -> all outputs 0 next cycle, no done pulse; a fresh start afterwards produces a correct result.
